pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register: successor to the fixed-width, always-advancing stage registers (ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake with a 2-entry skid buffer, so stalls propagate without a combinational ready path.
- Adds a flush that inserts bubbles.
- Carries a control field that is forced to zero whenever the stage holds no valid instruction, so downstream write enables can never fire on a bubble.

Parameters:
- DATA_W, 96: datapath payload width in bits (address/result/store data/destination fields, concatenated by the instantiator).
- CTRL_W, 8: control payload width (MemWr, MemRead, Branch, MemtoReg, RegWr, ...); zeroed on bubble.
- OPC_W, 6: opcode field width, carried alongside the control payload.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0, released synchronously to clk by the top level).
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  datapath payload.
- in_ctrl  in  CTRL_W  control payload.
- in_opc  in  OPC_W  opcode.
- out_valid  out  1  stage presents an instruction downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  datapath payload.
- out_ctrl  out  CTRL_W  control payload; all-zero when out_valid=0.
- out_opc  out  OPC_W  opcode; all-zero when out_valid=0.
- occupancy  out  2  number of held entries (0, 1 or 2).

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each entry has a valid bit plus data, ctrl and opc.
- Reset (reset=0, async):
  - M.valid=0, S.valid=0; all data/ctrl/opc registers cleared to 0.
  - in_ready=1, out_valid=0, out_*=0, occupancy=0.
- in_ready is registered and equals !S.valid. There is no combinational path from out_ready to in_ready.
- Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
- out_valid = M.valid. out_data = M.data. out_ctrl and out_opc = M.ctrl and M.opc gated by M.valid (gate or zero-on-load; either way, 0 when invalid).
- Per-cycle update, in the absence of flush:
  - M empty or delivering, S empty: an accept loads M (latency 1 cycle to out_valid). No accept leaves M empty.
  - M full, not delivering, accept: the input goes to S; in_ready drops next cycle.
  - M delivering, S full: S moves to M and S empties. in_ready was 0, so no accept is possible in this cycle.
  - M full, not delivering, no accept: hold all.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Order: FIFO order is preserved, so S is never delivered before M.
- Flush (highest priority):
  - Next cycle M.valid=0, S.valid=0, M.ctrl=0, M.opc=0, occupancy=0, in_ready=1.
  - An accept coinciding with flush is discarded.
  - A delivery coinciding with flush still counts downstream; the instantiator guarantees downstream ignores it if required.
- Reset mid-operation: immediately returns to the reset state. No entry survives.
- occupancy = M.valid + S.valid; it is never 2 while in_ready=1.
- Data width rules: payload is passed bit-exact with no arithmetic; widths are set only by the parameters.

Decomposition:
- Shared package pipe_pkg holds:
  - the default widths;
  - a localparam for the control bit positions (MEMWR_BIT, MEMREAD_BIT, BRANCH_BIT, MEMTOREG_LSB/MSB, REGWR_BIT), so all stages agree on the packing of the ctrl field.
- One natural sub-module: pipe_skid_entry, a single entry (valid bit + payload) with load, clear and hold controls, instantiated twice for M and S.
- The handshake and flush logic lives in the top module.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and in_ctrl=8'hFF -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0. Release -> first accept appears on out_data after 1 cycle.
- Streaming: out_ready=1, send data 1..10 back-to-back -> out_data=1..10 on consecutive cycles, starting one cycle after the first accept, with in_ready constant 1.
- Stall/skid: send A, B, C with out_ready=0 from the cycle after A is accepted:
  - A is held on the outputs, B is captured in S, occupancy=2, in_ready=0, and C is held upstream;
  - raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush with full buffer: occupancy=2, assert flush together with in_valid=1 and data D:
  - next cycle out_valid=0, out_ctrl=0, out_opc=0, occupancy=0, in_ready=1;
  - D never appears on the outputs.
- Bubble gating: accept an entry with in_ctrl=8'h11 and let it be delivered with in_valid=0 following -> next cycle out_valid=0 and out_ctrl=0 (not 8'h11).
- Async reset mid-stall: occupancy=2, pulse reset low between clock edges -> outputs clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, ctrl field packing and entry op encoding
//
// Package contents:
//   DEF_DATA_W / DEF_CTRL_W / DEF_OPC_W : default stage payload widths
//   *_BIT / *_LSB / *_MSB               : bit positions inside the ctrl field
//   entry_op_e                          : per-cycle command for one held entry
//   count_valid()                       : number of valid entries out of two
package pipe_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_OPC_W  = 6;

  // Packing of the ctrl field. Every stage register and every consumer
  // decodes ctrl through these positions, so they must stay in one place.
  localparam int MEMWR_BIT    = 0;
  localparam int MEMREAD_BIT  = 1;
  localparam int BRANCH_BIT   = 2;
  localparam int MEMTOREG_LSB = 3;
  localparam int MEMTOREG_MSB = 4;
  localparam int REGWR_BIT    = 5;

  // HOLD keeps the entry, LOAD captures a new valid payload, CLEAR empties
  // the entry and zeroes its payload.
  typedef enum logic [1:0] {
    ENTRY_HOLD  = 2'd0,
    ENTRY_LOAD  = 2'd1,
    ENTRY_CLEAR = 2'd2
  } entry_op_e;

  function automatic logic [1:0] count_valid(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - one held pipeline entry: valid bit plus payload
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset, clears valid and payload
//   op_i     HOLD / LOAD / CLEAR command for this cycle
//   data_i   payload captured on LOAD
//   ctrl_i   control field captured on LOAD
//   opc_i    opcode captured on LOAD
//   valid_o  entry holds an instruction
//   data_o   held payload
//   ctrl_o   held control field (zero whenever the entry is empty)
//   opc_o    held opcode (zero whenever the entry is empty)
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  entry_op_e         op_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [OPC_W-1:0]  opc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [OPC_W-1:0]  opc_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  logic [OPC_W-1:0]  opc_q,   opc_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    opc_d   = opc_q;
    case (op_i)
      ENTRY_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_i;
        ctrl_d  = ctrl_i;
        opc_d   = opc_i;
      end
      ENTRY_CLEAR: begin
        // Zero-on-clear keeps ctrl/opc at zero for as long as the entry is
        // empty, independent of any gating done by the instantiator.
        valid_d = 1'b0;
        data_d  = '0;
        ctrl_d  = '0;
        opc_d   = '0;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
      opc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      opc_q   <= opc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
  assign opc_o   = opc_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with skid buffer and flush
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous kill of all held entries; drops a coincident accept
//   in_valid   upstream presents an instruction
//   in_ready   stage can accept (registered, equals "skid entry empty")
//   in_data    datapath payload
//   in_ctrl    control payload
//   in_opc     opcode
//   out_valid  stage presents an instruction downstream
//   out_ready  downstream accepts this cycle
//   out_data   datapath payload of the main entry
//   out_ctrl   control payload, zero whenever out_valid is low
//   out_opc    opcode, zero whenever out_valid is low
//   occupancy  number of held entries (0..2)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int OPC_W  = DEF_OPC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [OPC_W-1:0]  in_opc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OPC_W-1:0]  out_opc,
  output logic [1:0]        occupancy
);

  // Main entry M drives the outputs; skid entry S catches the one
  // instruction that arrives while M is stalled.
  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data,  s_data;
  logic [CTRL_W-1:0] m_ctrl,  s_ctrl;
  logic [OPC_W-1:0]  m_opc,   s_opc;

  entry_op_e         m_op, s_op;
  logic              m_from_s;
  logic [DATA_W-1:0] m_data_src;
  logic [CTRL_W-1:0] m_ctrl_src;
  logic [OPC_W-1:0]  m_opc_src;

  logic accept, deliver;

  // S is a flop, so in_ready never depends combinationally on out_ready.
  assign in_ready = ~s_valid;
  assign accept   = in_valid & in_ready;
  assign deliver  = m_valid & out_ready;

  always_comb begin
    m_op     = ENTRY_HOLD;
    s_op     = ENTRY_HOLD;
    m_from_s = 1'b0;
    if (flush) begin
      m_op = ENTRY_CLEAR;
      s_op = ENTRY_CLEAR;
    end else if (s_valid) begin
      // in_ready is low, so no accept can happen; only a delivery moves
      // the skid entry forward, which preserves FIFO order.
      if (deliver) begin
        m_op     = ENTRY_LOAD;
        m_from_s = 1'b1;
        s_op     = ENTRY_CLEAR;
      end
    end else if (!m_valid || deliver) begin
      m_op = accept ? ENTRY_LOAD : ENTRY_CLEAR;
    end else if (accept) begin
      s_op = ENTRY_LOAD;
    end
  end

  always_comb begin
    m_data_src = in_data;
    m_ctrl_src = in_ctrl;
    m_opc_src  = in_opc;
    if (m_from_s) begin
      m_data_src = s_data;
      m_ctrl_src = s_ctrl;
      m_opc_src  = s_opc;
    end
  end

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .OPC_W  (OPC_W)
  ) u_main (
    .clk_i   (clk),
    .rst_ni  (reset),
    .op_i    (m_op),
    .data_i  (m_data_src),
    .ctrl_i  (m_ctrl_src),
    .opc_i   (m_opc_src),
    .valid_o (m_valid),
    .data_o  (m_data),
    .ctrl_o  (m_ctrl),
    .opc_o   (m_opc)
  );

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .OPC_W  (OPC_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (reset),
    .op_i    (s_op),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .opc_i   (in_opc),
    .valid_o (s_valid),
    .data_o  (s_data),
    .ctrl_o  (s_ctrl),
    .opc_o   (s_opc)
  );

  assign out_valid = m_valid;
  assign out_data  = m_data;
  // Gated as well as zero-on-clear so a bubble can never carry write enables.
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_opc   = m_valid ? m_opc  : '0;
  assign occupancy = count_valid(m_valid, s_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [7:0]  in_ctrl;
  logic [5:0]  in_opc;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [7:0]  out_ctrl;
  logic [5:0]  out_opc;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [95:0] data;
    logic [7:0]  ctrl;
    logic [5:0]  opc;
  } ent_t;

  ent_t q[$];

  logic [95:0] d_val;
  logic        d_seen = 1'b0;

  pipe_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_opc    (in_opc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_opc   (out_opc),
    .occupancy (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of capacity two. Ready means "fewer than two held";
  // a delivery pops the head, an accept appends; flush or reset empties it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else if (q.size() < 2) begin
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid) q.push_back('{in_data, in_ctrl, in_opc});
    end else if (out_ready) begin
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin
    check("out_valid", {127'd0, out_valid}, {127'd0, q.size() > 0});
    check("in_ready",  {127'd0, in_ready},  {127'd0, q.size() < 2});
    check("occupancy", {126'd0, occupancy}, 128'(q.size()));
    if (q.size() > 0) begin
      check("out_data", {32'd0, out_data},  {32'd0, q[0].data});
      check("out_ctrl", {120'd0, out_ctrl}, {120'd0, q[0].ctrl});
      check("out_opc",  {122'd0, out_opc},  {122'd0, q[0].opc});
    end else begin
      check("bubble_ctrl", {120'd0, out_ctrl}, 128'd0);
      check("bubble_opc",  {122'd0, out_opc},  128'd0);
    end
    if (out_valid && out_data == d_val) d_seen = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [95:0] d, input logic [7:0] c, input logic [5:0] o);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_opc   = o;
  endtask

  initial begin
    logic [95:0] da, db, dc;
    da    = 96'hA5A5_0000_1111_2222_3333_4444;
    db    = 96'h0000_BBBB_0000_BBBB_0000_BBBB;
    dc    = 96'hC0C0_C0C0_1234_5678_9ABC_DEF0;
    d_val = 96'hDEAD_BEEF_0D0D_0D0D_F00D_CAFE;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #1 reset = 1'b0;

    // reset held with a live input
    drive(1'b1, da, 8'hFF, 6'h3F);
    step();
    step();
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_out_ctrl",  {120'd0, out_ctrl},  128'd0);
    check("rst_in_ready",  {127'd0, in_ready},  128'd1);
    check("rst_occupancy", {126'd0, occupancy}, 128'd0);

    // release, first accept visible one cycle later
    reset = 1'b1;
    drive(1'b1, da, 8'h5A, 6'h15);
    step();
    check("first_valid", {127'd0, out_valid}, 128'd1);
    check("first_data",  {32'd0, out_data},   {32'd0, da});
    check("first_ctrl",  {120'd0, out_ctrl},  128'h5A);
    check("first_opc",   {122'd0, out_opc},   128'h15);
    check("first_occ",   {126'd0, occupancy}, 128'd1);
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);
    step();

    // streaming 1..10 back-to-back
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 96'(i), 8'(i), 6'(i));
      step();
      check("stream_data",  {32'd0, out_data},  128'(i));
      check("stream_ready", {127'd0, in_ready}, 128'd1);
    end
    drive(1'b0, '0, '0, '0);
    step();
    check("stream_drain", {127'd0, out_valid}, 128'd0);

    // stall / skid: A held, B in skid, C waits upstream
    drive(1'b1, da, 8'h01, 6'h01);
    step();
    out_ready = 1'b0;
    drive(1'b1, db, 8'h02, 6'h02);
    step();
    check("skid_occ",   {126'd0, occupancy}, 128'd2);
    check("skid_ready", {127'd0, in_ready},  128'd0);
    check("skid_head",  {32'd0, out_data},   {32'd0, da});
    drive(1'b1, dc, 8'h03, 6'h03);
    step();
    check("skid_hold_head", {32'd0, out_data},   {32'd0, da});
    check("skid_hold_occ",  {126'd0, occupancy}, 128'd2);
    out_ready = 1'b1;
    step();
    check("skid_order_b", {32'd0, out_data},   {32'd0, db});
    check("skid_occ_b",   {126'd0, occupancy}, 128'd1);
    step();
    check("skid_order_c", {32'd0, out_data}, {32'd0, dc});
    drive(1'b0, '0, '0, '0);
    step();
    check("skid_empty", {127'd0, out_valid}, 128'd0);

    // flush with a full buffer and a coincident input D
    out_ready = 1'b0;
    drive(1'b1, da, 8'h0F, 6'h0F);
    step();
    drive(1'b1, db, 8'h0E, 6'h0E);
    step();
    check("flush_pre_occ", {126'd0, occupancy}, 128'd2);
    flush = 1'b1;
    drive(1'b1, d_val, 8'hFF, 6'h3F);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    check("flush_valid", {127'd0, out_valid}, 128'd0);
    check("flush_ctrl",  {120'd0, out_ctrl},  128'd0);
    check("flush_opc",   {122'd0, out_opc},   128'd0);
    check("flush_occ",   {126'd0, occupancy}, 128'd0);
    check("flush_ready", {127'd0, in_ready},  128'd1);
    out_ready = 1'b1;
    step();
    check("flush_no_d", {127'd0, out_valid}, 128'd0);

    // bubble gating after a delivered 8'h11 entry
    drive(1'b1, dc, 8'h11, 6'h21);
    step();
    check("gate_loaded", {120'd0, out_ctrl}, 128'h11);
    drive(1'b0, '0, '0, '0);
    step();
    check("gate_valid", {127'd0, out_valid}, 128'd0);
    check("gate_ctrl",  {120'd0, out_ctrl},  128'd0);

    // async reset mid-stall, observed before any clock edge
    out_ready = 1'b0;
    drive(1'b1, da, 8'h44, 6'h04);
    step();
    drive(1'b1, db, 8'h55, 6'h05);
    step();
    check("areset_pre_occ", {126'd0, occupancy}, 128'd2);
    #2 reset = 1'b0;
    #1;
    check("areset_valid", {127'd0, out_valid}, 128'd0);
    check("areset_ctrl",  {120'd0, out_ctrl},  128'd0);
    check("areset_occ",   {126'd0, occupancy}, 128'd0);
    check("areset_ready", {127'd0, in_ready},  128'd1);
    step();
    reset = 1'b1;

    // randomized traffic against the FIFO reference
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {$urandom, $urandom, $urandom};
      in_ctrl   = 8'($urandom);
      in_opc    = 6'($urandom);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    check("drained", {127'd0, out_valid}, 128'd0);
    check("d_never_seen", {127'd0, d_seen}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
